// File: rtl/conv10_ofm_writer_if.sv
// Bus between the conv10 output stage and the OFM RAM writer: layer control,
// output-vector strobe, RAM write port and status flags.
interface conv10_ofm_writer_if #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 512,
  parameter int ADDR_W = 15
);
  logic              layer_start_i;
  logic              layer_sel_i;
  logic              sample_i;
  logic [WIDTH-1:0]  ofm_i [0:DSP_NO-1];
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [WIDTH-1:0]  wr_data_o;
  logic              ram_feedback_1;
  logic              ram_feedback_2;
  logic              busy_o;
  logic              overrun_o;

  modport master (
    output layer_start_i, layer_sel_i, sample_i, ofm_i,
    input  wr_en_o, wr_addr_o, wr_data_o, ram_feedback_1, ram_feedback_2,
           busy_o, overrun_o
  );

  modport slave (
    input  layer_start_i, layer_sel_i, sample_i, ofm_i,
    output wr_en_o, wr_addr_o, wr_data_o, ram_feedback_1, ram_feedback_2,
           busy_o, overrun_o
  );
endinterface

// File: rtl/conv10_ofm_writer.sv
// conv10 output feature-map writer: captures one DSP_NO-wide output vector per
// sample pulse and serialises it into the OFM RAM, pixel-major
// (addr = pixel*DSP_NO + channel), then pulses the per-layer feedback.
module conv10_ofm_writer #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 512,
  parameter int WOUT   = 8,
  parameter int ADDR_W = $clog2(DSP_NO*WOUT*WOUT)
) (
  input logic                 clk,
  input logic                 rst,
  conv10_ofm_writer_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int PIXELS = WOUT*WOUT;
  localparam int CH_W   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam bit POW2   = ((DSP_NO & (DSP_NO-1)) == 0);

  logic [1:0]        state;
  logic              sel;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   ch_nxt;
  logic [PIX_W-1:0]  pix;
  logic [WIDTH-1:0]  shadow [0:DSP_NO-1];
  logic              capture;
  logic              last_ch;
  logic              last_pix;
  logic [ADDR_W-1:0] word_addr;

  // ch is the channel currently on the registered write port; ch_nxt is the
  // one being loaded on this edge (0 on the capture edge).
  assign capture  = (state == ARMED) && bus.sample_i;
  assign last_ch  = (ch == CH_W'(DSP_NO-1));
  assign last_pix = (pix == PIX_W'(PIXELS-1));
  assign ch_nxt   = capture ? '0 : ch + 1'b1;
  assign bus.busy_o = (state != IDLE);

  generate
    if (POW2) begin : g_concat
      assign word_addr = ADDR_W'({pix, ch_nxt});
    end else begin : g_base
      logic [ADDR_W-1:0] base;
      // Running pixel base address, advanced by DSP_NO after every pixel.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          base <= '0;
        else if (state == IDLE && bus.layer_start_i)
          base <= '0;
        else if (state == DRAIN && last_ch)
          base <= base + ADDR_W'(DSP_NO);
      end
      assign word_addr = base + ADDR_W'(ch_nxt);
    end
  endgenerate

  // Shadow copy of the output vector, taken only when a sample is accepted.
  always_ff @(posedge clk) begin
    if (capture)
      shadow <= bus.ofm_i;
  end

  // Writer FSM with registered RAM write port, feedback pulses and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      sel                <= 1'b0;
      ch                 <= '0;
      pix                <= '0;
      bus.wr_en_o        <= 1'b0;
      bus.wr_addr_o      <= '0;
      bus.wr_data_o      <= '0;
      bus.ram_feedback_1 <= 1'b0;
      bus.ram_feedback_2 <= 1'b0;
      bus.overrun_o      <= 1'b0;
    end else begin
      bus.ram_feedback_1 <= 1'b0;
      bus.ram_feedback_2 <= 1'b0;
      if (bus.sample_i && (state == DRAIN || state == DONE))
        bus.overrun_o <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.layer_start_i) begin
            sel   <= bus.layer_sel_i;
            pix   <= '0;
            state <= ARMED;
          end
        end
        ARMED: begin
          if (bus.sample_i) begin
            // First word comes straight from the input so the burst starts
            // the cycle after the capture edge.
            ch            <= '0;
            bus.wr_en_o   <= 1'b1;
            bus.wr_addr_o <= word_addr;
            bus.wr_data_o <= bus.ofm_i[0];
            state         <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_ch) begin
            bus.wr_en_o <= 1'b0;
            pix         <= pix + 1'b1;
            if (last_pix) begin
              bus.ram_feedback_1 <= ~sel;
              bus.ram_feedback_2 <= sel;
              state              <= DONE;
            end else begin
              state <= ARMED;
            end
          end else begin
            ch            <= ch_nxt;
            bus.wr_addr_o <= word_addr;
            bus.wr_data_o <= shadow[ch_nxt];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
